mod_updown_counter: RTL and testbench

Parametrised successor to the team's 4-bit enable-gated binary counter. It generalises width and modulus and adds up/down direction, synchronous clear and load, wrap or saturate mode, an enable prescaler, a terminal-count pulse and a sticky overflow flag. It is used as the general-purpose event/tick counter across the design. Default parameters reproduce a plain 4-bit wrapping up-counter.

---
 rtl/mod_updown_counter.sv | 77 +++++++
 tb/tb_mod_updown_counter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
// General-purpose event/tick counter: up/down, modulo MAX_VAL+1, wrap or saturate,
// enable prescaler, one-cycle terminal-count pulse and sticky overflow flag.
module mod_updown_counter #(
  parameter int          WIDTH    = 4,
  parameter int unsigned MAX_VAL  = 15,
  parameter int          PRESCALE = 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_limit,
  output logic             overflow
);

  localparam int PW = $clog2(PRESCALE) + 1;
  localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_VAL);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("mod_updown_counter: WIDTH must be in 1..32");
  end
  if (MAX_VAL < 1 || 64'(MAX_VAL) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("mod_updown_counter: MAX_VAL must be in 1..2^WIDTH-1");
  end
  if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_pre
    $error("mod_updown_counter: PRESCALE must be in 1..256");
  end

  logic [PW-1:0] pre_cnt;
  logic          step;

  assign step     = enable && (pre_cnt == PRE_LAST);
  assign at_limit = up_dn ? (count == MAX_C) : (count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      pre_cnt  <= '0;
      tc       <= 1'b0;
      overflow <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      pre_cnt  <= '0;
      tc       <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      // Clamp so count can never leave 0..MAX_VAL, even for an out-of-range load.
      count   <= (load_val > MAX_C) ? MAX_C : load_val;
      pre_cnt <= '0;
      tc      <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (enable) begin
        pre_cnt <= step ? '0 : pre_cnt + 1'b1;
      end
      if (step) begin
        if (at_limit) begin
          tc       <= 1'b1;
          overflow <= 1'b1;
          if (!SATURATE) begin
            count <= up_dn ? '0 : MAX_C;
          end
        end else begin
          count <= up_dn ? count + 1'b1 : count - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: four instances (defaults, MAX_VAL=9 wrap,
// MAX_VAL=9 saturate, PRESCALE=3), expected values queued then popped per cycle.
module tb_mod_updown_counter;

  typedef struct {
    string      name;
    logic [3:0] count;
    logic       tc;
    logic       ovf;
  } exp_t;

  typedef struct {
    bit         clr;
    bit         ld;
    logic [3:0] lv;
    bit         en;
    bit         up;
    logic [3:0] c;
    bit         tc;
    bit         ovf;
  } row_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic clk;
  logic reset;

  logic       def_en, def_up, def_clr, def_ld;
  logic [3:0] def_lv, def_count;
  logic       def_tc, def_at, def_ovf;

  logic       m9_en, m9_up, m9_clr, m9_ld;
  logic [3:0] m9_lv, m9_count;
  logic       m9_tc, m9_at, m9_ovf;

  logic       sat_en, sat_up, sat_clr, sat_ld;
  logic [3:0] sat_lv, sat_count;
  logic       sat_tc, sat_at, sat_ovf;

  logic       pre_en, pre_up, pre_clr, pre_ld;
  logic [3:0] pre_lv, pre_count;
  logic       pre_tc, pre_at, pre_ovf;

  mod_updown_counter u_def (
    .clk(clk), .reset(reset), .enable(def_en), .up_dn(def_up), .clear(def_clr),
    .load(def_ld), .load_val(def_lv), .count(def_count), .tc(def_tc),
    .at_limit(def_at), .overflow(def_ovf)
  );

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(9)) u_m9 (
    .clk(clk), .reset(reset), .enable(m9_en), .up_dn(m9_up), .clear(m9_clr),
    .load(m9_ld), .load_val(m9_lv), .count(m9_count), .tc(m9_tc),
    .at_limit(m9_at), .overflow(m9_ovf)
  );

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .enable(sat_en), .up_dn(sat_up), .clear(sat_clr),
    .load(sat_ld), .load_val(sat_lv), .count(sat_count), .tc(sat_tc),
    .at_limit(sat_at), .overflow(sat_ovf)
  );

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(15), .PRESCALE(3)) u_pre (
    .clk(clk), .reset(reset), .enable(pre_en), .up_dn(pre_up), .clear(pre_clr),
    .load(pre_ld), .load_val(pre_lv), .count(pre_count), .tc(pre_tc),
    .at_limit(pre_at), .overflow(pre_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    def_en = 0; def_up = 1; def_clr = 0; def_ld = 0; def_lv = '0;
    m9_en  = 0; m9_up  = 0; m9_clr  = 0; m9_ld  = 0; m9_lv  = '0;
    sat_en = 0; sat_up = 1; sat_clr = 0; sat_ld = 0; sat_lv = '0;
    pre_en = 0; pre_up = 1; pre_clr = 0; pre_ld = 0; pre_lv = '0;
    tick();
    tick();
    checks++; if (def_count !== 4'd0) begin errors++; $display("FAIL reset def_count: got %0d expected 0", def_count); end
    checks++; if (def_tc !== 1'b0) begin errors++; $display("FAIL reset def_tc: got %b expected 0", def_tc); end
    checks++; if (def_ovf !== 1'b0) begin errors++; $display("FAIL reset def_ovf: got %b expected 0", def_ovf); end
    checks++; if (def_at !== 1'b0) begin errors++; $display("FAIL reset def_at_limit: got %b expected 0", def_at); end
    checks++; if (m9_count !== 4'd0) begin errors++; $display("FAIL reset m9_count: got %0d expected 0", m9_count); end
    checks++; if (m9_at !== 1'b1) begin errors++; $display("FAIL reset m9_at_limit(down): got %b expected 1", m9_at); end
    checks++; if (sat_count !== 4'd0) begin errors++; $display("FAIL reset sat_count: got %0d expected 0", sat_count); end
    checks++; if (pre_count !== 4'd0) begin errors++; $display("FAIL reset pre_count: got %0d expected 0", pre_count); end
    reset = 1'b1;
  endtask

  task automatic test_wrap_up();
    exp_t e;
    for (int i = 1; i <= 20; i++)
      sb.push_back('{$sformatf("wrap_up%0d", i), 4'(i % 16), (i == 16), (i >= 16)});
    def_en = 1; def_up = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      e = sb.pop_front();
      checks++; if (def_count !== e.count) begin errors++; $display("FAIL %s count: got %0d expected %0d", e.name, def_count, e.count); end
      checks++; if (def_tc !== e.tc) begin errors++; $display("FAIL %s tc: got %b expected %b", e.name, def_tc, e.tc); end
      checks++; if (def_ovf !== e.ovf) begin errors++; $display("FAIL %s ovf: got %b expected %b", e.name, def_ovf, e.ovf); end
      checks++; if (def_at !== (e.count == 4'd15)) begin errors++; $display("FAIL %s at_limit: got %b expected %b", e.name, def_at, (e.count == 4'd15)); end
    end
    def_en = 0;
  endtask

  task automatic test_down_wrap();
    exp_t e;
    sb.push_back('{"down1", 4'd9, 1'b1, 1'b1});
    sb.push_back('{"down2", 4'd8, 1'b0, 1'b1});
    sb.push_back('{"down3", 4'd7, 1'b0, 1'b1});
    m9_en = 1; m9_up = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = sb.pop_front();
      checks++; if (m9_count !== e.count) begin errors++; $display("FAIL %s count: got %0d expected %0d", e.name, m9_count, e.count); end
      checks++; if (m9_tc !== e.tc) begin errors++; $display("FAIL %s tc: got %b expected %b", e.name, m9_tc, e.tc); end
      checks++; if (m9_ovf !== e.ovf) begin errors++; $display("FAIL %s ovf: got %b expected %b", e.name, m9_ovf, e.ovf); end
    end
    m9_en = 0;
  endtask

  task automatic test_saturate();
    exp_t e;
    row_t rows[9];
    rows = '{
      '{0, 1, 4'd8, 0, 1, 4'd8, 0, 0},
      '{0, 0, 4'd0, 1, 1, 4'd9, 0, 0},
      '{0, 0, 4'd0, 1, 1, 4'd9, 1, 1},
      '{0, 0, 4'd0, 1, 1, 4'd9, 1, 1},
      '{0, 0, 4'd0, 1, 1, 4'd9, 1, 1},
      '{0, 0, 4'd0, 0, 1, 4'd9, 0, 1},
      '{1, 0, 4'd0, 0, 1, 4'd0, 0, 0},
      '{0, 0, 4'd0, 1, 0, 4'd0, 1, 1},
      '{1, 0, 4'd0, 0, 0, 4'd0, 0, 0}
    };
    for (int i = 0; i < 9; i++)
      sb.push_back('{$sformatf("sat%0d", i), rows[i].c, rows[i].tc, rows[i].ovf});
    for (int i = 0; i < 9; i++) begin
      sat_clr = rows[i].clr; sat_ld = rows[i].ld; sat_lv = rows[i].lv;
      sat_en = rows[i].en; sat_up = rows[i].up;
      tick();
      e = sb.pop_front();
      checks++; if (sat_count !== e.count) begin errors++; $display("FAIL %s count: got %0d expected %0d", e.name, sat_count, e.count); end
      checks++; if (sat_tc !== e.tc) begin errors++; $display("FAIL %s tc: got %b expected %b", e.name, sat_tc, e.tc); end
      checks++; if (sat_ovf !== e.ovf) begin errors++; $display("FAIL %s ovf: got %b expected %b", e.name, sat_ovf, e.ovf); end
      if (i == 2) begin
        checks++; if (sat_at !== 1'b1) begin errors++; $display("FAIL sat_at_limit: got %b expected 1", sat_at); end
      end
    end
    sat_clr = 0; sat_en = 0;
  endtask

  task automatic test_prescale();
    exp_t e;
    bit         en_pat[14];
    bit         up_pat[14];
    logic [3:0] cnt_pat[14];
    en_pat  = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    up_pat  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    cnt_pat = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3, 3, 3, 2};
    for (int i = 0; i < 14; i++)
      sb.push_back('{$sformatf("pre%0d", i), cnt_pat[i], 1'b0, 1'b0});
    for (int i = 0; i < 14; i++) begin
      pre_en = en_pat[i]; pre_up = up_pat[i];
      tick();
      e = sb.pop_front();
      checks++; if (pre_count !== e.count) begin errors++; $display("FAIL %s count: got %0d expected %0d", e.name, pre_count, e.count); end
      checks++; if (pre_tc !== e.tc) begin errors++; $display("FAIL %s tc: got %b expected %b", e.name, pre_tc, e.tc); end
    end
    pre_en = 0;
  endtask

  task automatic test_priority();
    exp_t e;
    row_t rows[8];
    rows = '{
      '{1, 1, 4'd5,  0, 0, 4'd0, 0, 0},
      '{0, 1, 4'd12, 0, 0, 4'd9, 0, 0},
      '{0, 1, 4'd3,  1, 1, 4'd3, 0, 0},
      '{0, 0, 4'd0,  1, 1, 4'd4, 0, 0},
      '{0, 1, 4'd9,  0, 1, 4'd9, 0, 0},
      '{0, 0, 4'd0,  1, 1, 4'd0, 1, 1},
      '{0, 1, 4'd2,  1, 1, 4'd2, 0, 1},
      '{0, 0, 4'd0,  0, 1, 4'd2, 0, 1}
    };
    for (int i = 0; i < 8; i++)
      sb.push_back('{$sformatf("prio%0d", i), rows[i].c, rows[i].tc, rows[i].ovf});
    for (int i = 0; i < 8; i++) begin
      m9_clr = rows[i].clr; m9_ld = rows[i].ld; m9_lv = rows[i].lv;
      m9_en = rows[i].en; m9_up = rows[i].up;
      tick();
      e = sb.pop_front();
      checks++; if (m9_count !== e.count) begin errors++; $display("FAIL %s count: got %0d expected %0d", e.name, m9_count, e.count); end
      checks++; if (m9_tc !== e.tc) begin errors++; $display("FAIL %s tc: got %b expected %b", e.name, m9_tc, e.tc); end
      checks++; if (m9_ovf !== e.ovf) begin errors++; $display("FAIL %s ovf: got %b expected %b", e.name, m9_ovf, e.ovf); end
    end
    m9_ld = 0; m9_en = 0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    sb.push_back('{"ar_load", 4'd5, 1'b0, 1'b1});
    sb.push_back('{"ar_step", 4'd6, 1'b0, 1'b1});
    sb.push_back('{"ar_async", 4'd0, 1'b0, 1'b0});
    sb.push_back('{"ar_held", 4'd0, 1'b0, 1'b0});
    sb.push_back('{"ar_resume1", 4'd1, 1'b0, 1'b0});
    sb.push_back('{"ar_resume2", 4'd2, 1'b0, 1'b0});
    def_ld = 1; def_lv = 4'd5; def_en = 0; def_up = 1;
    for (int i = 0; i < 6; i++) begin
      case (i)
        1: begin def_ld = 0; def_en = 1; end
        2: begin #3; reset = 1'b0; end
        4: begin #3; reset = 1'b1; end
        default: ;
      endcase
      if (i == 2) #1;
      else tick();
      e = sb.pop_front();
      checks++; if (def_count !== e.count) begin errors++; $display("FAIL %s count: got %0d expected %0d", e.name, def_count, e.count); end
      checks++; if (def_tc !== e.tc) begin errors++; $display("FAIL %s tc: got %b expected %b", e.name, def_tc, e.tc); end
      checks++; if (def_ovf !== e.ovf) begin errors++; $display("FAIL %s ovf: got %b expected %b", e.name, def_ovf, e.ovf); end
    end
    def_en = 0;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_down_wrap();
    test_saturate();
    test_prescale();
    test_priority();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
